jellyvl_stream_window_position: RTL and testbench

//   Marks the beats of a framed stream that fall inside repeated windows. Each window is defined by

---
 rtl/jellyvl_stream_position_pkg.sv | 28 ++
 rtl/jellyvl_stream_position_phase_counter.sv | 31 +++
 rtl/jellyvl_stream_window_position.sv | 159 +++++++++++++++
 tb/tb_jellyvl_stream_window_position.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/jellyvl_stream_position_pkg.sv
// Shared types for the stream window position tracker.
// The parameter struct is sized for the default build widths.
package jellyvl_stream_position_pkg;

  localparam int POS_OFFSET_WIDTH = 16;
  localparam int POS_LENGTH_WIDTH = 16;
  localparam int POS_NUMBER_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    OFFSET,
    ACTIVE,
    GAP,
    DONE
  } t_pos_state;

  typedef struct packed {
    logic [POS_OFFSET_WIDTH-1:0] offset;
    logic [POS_LENGTH_WIDTH-1:0] length;
    logic [POS_LENGTH_WIDTH-1:0] step;
    logic [POS_NUMBER_WIDTH-1:0] number;
  } t_pos_param;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jellyvl_stream_position_phase_counter.sv
// Loadable up-counter with an equality flag against a terminal value.
// Load wins over increment; both are gated by cke; no backpressure.
module jellyvl_stream_position_phase_counter #(
  parameter int WIDTH = 16
) (
  input  logic             reset,
  input  logic             clk,
  input  logic             cke,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] count,
  output logic             match
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (cke) begin
      if (load) begin
        count <= load_value;
      end else if (inc) begin
        count <= count + WIDTH'(1);
      end
    end
  end

  assign match = (count == target);

endmodule

// File: rtl/jellyvl_stream_window_position.sv
// Flags beats of a framed stream that fall inside repeated OFFSET/LENGTH/STEP windows.
// Outputs registered, latency 1 beat; no backpressure, cke freezes everything.
module jellyvl_stream_window_position
  import jellyvl_stream_position_pkg::*;
#(
  parameter int OFFSET_WIDTH = POS_OFFSET_WIDTH,
  parameter int LENGTH_WIDTH = POS_LENGTH_WIDTH,
  parameter int NUMBER_WIDTH = POS_NUMBER_WIDTH,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    reset,
  input  logic                    clk,
  input  logic                    cke,
  input  logic [OFFSET_WIDTH-1:0] param_offset,
  input  logic [LENGTH_WIDTH-1:0] param_length,
  input  logic [LENGTH_WIDTH-1:0] param_step,
  input  logic [NUMBER_WIDTH-1:0] param_number,
  input  logic                    stream_first,
  input  logic                    stream_enable,
  input  logic                    stream_valid,
  output logic                    position_first,
  output logic                    position_last,
  output logic [COUNT_WIDTH-1:0]  position_count,
  output logic [NUMBER_WIDTH-1:0] position_index,
  output logic                    position_valid,
  output logic                    position_busy
);

  localparam int PW  = max_int(OFFSET_WIDTH, LENGTH_WIDTH) + 1;
  localparam int LW1 = LENGTH_WIDTH + 1;
  localparam int NW1 = NUMBER_WIDTH + 1;

  t_pos_state state, state_next;
  t_pos_param prm;
  logic [NUMBER_WIDTH-1:0] index_reg;

  logic beat, start, abort, step_beat, act;
  logic [LENGTH_WIDTH-1:0] in_step_eff;
  logic [PW-1:0]  cur_offset;
  logic [LW1-1:0] cur_len, cur_step, len_m1, gap;
  logic [NW1-1:0] cur_number;

  logic emit, emit_start, emit_last, win_done;
  logic [COUNT_WIDTH-1:0]  emit_count;
  logic [NUMBER_WIDTH-1:0] emit_index;

  logic            ph_load, ph_inc, ph_match;
  logic [PW-1:0]   ph_target, ph_count;
  logic            cnt_load, cnt_inc, cnt_match;
  logic [COUNT_WIDTH-1:0] cnt_load_value, cnt_count;

  assign beat      = cke & stream_valid;
  assign start     = beat & stream_first & stream_enable;
  assign abort     = beat & ~stream_enable;
  assign step_beat = beat & ~stream_first & stream_enable;
  assign act       = step_beat & (state == ACTIVE);

  // On the first beat the live inputs apply; afterwards the latched copy.
  assign in_step_eff = (param_step > param_length) ? param_step : param_length;
  assign cur_offset  = start ? PW'(param_offset)  : PW'(prm.offset);
  assign cur_len     = start ? LW1'(param_length) : LW1'(prm.length);
  assign cur_step    = start ? LW1'(in_step_eff)  : LW1'(prm.step);
  assign cur_number  = start ? NW1'(param_number) : NW1'(prm.number);
  assign len_m1      = LW1'(prm.length) - LW1'(1);
  assign gap         = LW1'(prm.step) - LW1'(prm.length);

  assign emit_start = (cur_len != '0) && (cur_offset == '0);
  assign emit = start ? emit_start
                      : (step_beat & (((state == OFFSET) & ph_match) | (state == ACTIVE)));
  assign emit_count = act ? cnt_count : '0;
  assign emit_last  = act ? cnt_match : (cur_len == LW1'(1));
  assign emit_index = start ? '0 : index_reg;
  assign win_done   = (cur_number != '0) && ((NW1'(emit_index) + NW1'(1)) == cur_number);

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else if (emit) begin
      if (!emit_last)                state_next = ACTIVE;
      else if (win_done)             state_next = DONE;
      else if (cur_step == cur_len)  state_next = ACTIVE;
      else                           state_next = GAP;
    end else if (start) begin
      state_next = (cur_len == '0) ? DONE : OFFSET;
    end else if (step_beat && (state == GAP) && ph_match) begin
      state_next = ACTIVE;
    end
  end

  assign ph_target = (state == GAP) ? PW'(gap) : PW'(prm.offset);
  assign ph_load   = start | (emit & emit_last);
  assign ph_inc    = step_beat & ((state == OFFSET) | (state == GAP)) & ~ph_match;

  // Window counter holds the count of the next ACTIVE beat.
  assign cnt_load       = start | (emit & (emit_last | ~act));
  assign cnt_load_value = (emit & ~emit_last) ? COUNT_WIDTH'(1) : '0;
  assign cnt_inc        = act & ~emit_last;

  jellyvl_stream_position_phase_counter #(.WIDTH(PW)) u_phase (
    .reset      (reset),
    .clk        (clk),
    .cke        (cke),
    .load       (ph_load),
    .load_value (PW'(1)),
    .inc        (ph_inc),
    .target     (ph_target),
    .count      (ph_count),
    .match      (ph_match)
  );

  jellyvl_stream_position_phase_counter #(.WIDTH(COUNT_WIDTH)) u_count (
    .reset      (reset),
    .clk        (clk),
    .cke        (cke),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .inc        (cnt_inc),
    .target     (COUNT_WIDTH'(len_m1)),
    .count      (cnt_count),
    .match      (cnt_match)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      prm            <= '0;
      index_reg      <= '0;
      position_first <= 1'b0;
      position_last  <= 1'b0;
      position_count <= '0;
      position_index <= '0;
      position_valid <= 1'b0;
    end else if (cke) begin
      state          <= state_next;
      position_valid <= emit;
      if (start) begin
        prm.offset <= POS_OFFSET_WIDTH'(param_offset);
        prm.length <= POS_LENGTH_WIDTH'(param_length);
        prm.step   <= POS_LENGTH_WIDTH'(in_step_eff);
        prm.number <= POS_NUMBER_WIDTH'(param_number);
      end
      if (emit && emit_last) begin
        index_reg <= emit_index + NUMBER_WIDTH'(1);
      end else if (start) begin
        index_reg <= '0;
      end
      if (emit) begin
        position_first <= (emit_count == '0);
        position_last  <= emit_last;
        position_count <= emit_count;
        position_index <= emit_index;
      end
    end
  end

  assign position_busy = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_jellyvl_stream_window_position.sv
// Directed bench for jellyvl_stream_window_position with hand-computed expectations.
module tb_jellyvl_stream_window_position;

  logic        clk = 1'b0;
  logic        reset;
  logic        cke;
  logic [15:0] param_offset, param_length, param_step;
  logic [7:0]  param_number;
  logic        stream_first, stream_enable, stream_valid;
  logic        position_first, position_last, position_valid, position_busy;
  logic [15:0] position_count;
  logic [7:0]  position_index;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jellyvl_stream_window_position dut (
    .reset          (reset),
    .clk            (clk),
    .cke            (cke),
    .param_offset   (param_offset),
    .param_length   (param_length),
    .param_step     (param_step),
    .param_number   (param_number),
    .stream_first   (stream_first),
    .stream_enable  (stream_enable),
    .stream_valid   (stream_valid),
    .position_first (position_first),
    .position_last  (position_last),
    .position_count (position_count),
    .position_index (position_index),
    .position_valid (position_valid),
    .position_busy  (position_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_params(input int off, input int len, input int stp, input int num);
    param_offset = 16'(off);
    param_length = 16'(len);
    param_step   = 16'(stp);
    param_number = 8'(num);
  endtask

  task automatic beat(input logic f, input logic en);
    @(negedge clk);
    cke = 1'b1; stream_valid = 1'b1; stream_first = f; stream_enable = en;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    cke = 1'b1; stream_valid = 1'b0; stream_first = 1'b0; stream_enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Test 1 expectations (off=2, len=3, step=5, num=2)
  logic t1_v[12] = '{0,0,1,1,1,0,0,1,1,1,0,0};
  int   t1_c[12] = '{0,0,0,1,2,0,0,0,1,2,0,0};
  int   t1_i[12] = '{0,0,0,0,0,0,0,1,1,1,0,0};
  logic t1_b[12] = '{1,1,1,1,1,1,1,1,1,0,0,0};
  // Test 2 expectations (off=0, len=4, step=2 -> 4, unlimited)
  int   t2_c[10] = '{0,1,2,3,0,1,2,3,0,1};
  int   t2_i[10] = '{0,0,0,0,1,1,1,1,2,2};

  initial begin
    reset = 1'b0; cke = 1'b0; stream_valid = 1'b0; stream_first = 1'b0; stream_enable = 1'b0;
    set_params(0, 0, 0, 0);
    #12;
    chk("rst_valid", 32'(position_valid), 32'd0);
    chk("rst_busy",  32'(position_busy),  32'd0);
    chk("rst_count", 32'(position_count), 32'd0);
    chk("rst_index", 32'(position_index), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Test 1
    set_params(2, 3, 5, 2);
    for (int b = 0; b < 12; b++) begin
      beat(b == 0, 1'b1);
      chk($sformatf("t1_valid_b%0d", b), 32'(position_valid), 32'(t1_v[b]));
      chk($sformatf("t1_busy_b%0d", b),  32'(position_busy),  32'(t1_b[b]));
      if (t1_v[b]) begin
        chk($sformatf("t1_count_b%0d", b), 32'(position_count), 32'(t1_c[b]));
        chk($sformatf("t1_index_b%0d", b), 32'(position_index), 32'(t1_i[b]));
        chk($sformatf("t1_first_b%0d", b), 32'(position_first), 32'(t1_c[b] == 0));
        chk($sformatf("t1_last_b%0d", b),  32'(position_last),  32'(t1_c[b] == 2));
      end
    end

    // Test 2, with a non-beat cycle after beat 5
    set_params(0, 4, 2, 0);
    for (int b = 0; b < 10; b++) begin
      beat(b == 0, 1'b1);
      chk($sformatf("t2_valid_b%0d", b), 32'(position_valid), 32'd1);
      chk($sformatf("t2_count_b%0d", b), 32'(position_count), 32'(t2_c[b]));
      chk($sformatf("t2_index_b%0d", b), 32'(position_index), 32'(t2_i[b]));
      chk($sformatf("t2_last_b%0d", b),  32'(position_last),  32'(t2_c[b] == 3));
      if (b == 5) begin
        idle();
        chk("t2_idle_valid", 32'(position_valid), 32'd0);
        chk("t2_idle_count", 32'(position_count), 32'd1);
      end
    end

    // Test 3: restart at beat 5 with off=0, len=1
    set_params(2, 3, 5, 2);
    for (int b = 0; b < 5; b++) beat(b == 0, 1'b1);
    set_params(0, 1, 5, 2);
    beat(1'b1, 1'b1);
    chk("t3_valid", 32'(position_valid), 32'd1);
    chk("t3_first", 32'(position_first), 32'd1);
    chk("t3_last",  32'(position_last),  32'd1);
    chk("t3_index", 32'(position_index), 32'd0);
    chk("t3_count", 32'(position_count), 32'd0);
    beat(1'b0, 1'b1);
    chk("t3_gap_valid", 32'(position_valid), 32'd0);

    // Test 4: abort at beat 3
    set_params(2, 3, 5, 2);
    for (int b = 0; b < 3; b++) beat(b == 0, 1'b1);
    chk("t4_pre_valid", 32'(position_valid), 32'd1);
    beat(1'b0, 1'b0);
    chk("t4_abort_valid", 32'(position_valid), 32'd0);
    chk("t4_abort_busy",  32'(position_busy),  32'd0);
    for (int b = 4; b < 9; b++) begin
      beat(1'b0, 1'b1);
      chk($sformatf("t4_after_valid_b%0d", b), 32'(position_valid), 32'd0);
    end

    // Test 5: cke stall, then asynchronous reset mid-window
    set_params(2, 3, 5, 2);
    for (int b = 0; b < 3; b++) beat(b == 0, 1'b1);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      cke = 1'b0; stream_valid = 1'b1; stream_first = 1'b0; stream_enable = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("t5_stall_valid_%0d", s), 32'(position_valid), 32'd1);
      chk($sformatf("t5_stall_count_%0d", s), 32'(position_count), 32'd0);
    end
    beat(1'b0, 1'b1);
    chk("t5_resume_count", 32'(position_count), 32'd1);
    chk("t5_resume_valid", 32'(position_valid), 32'd1);
    @(negedge clk);
    stream_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(position_valid), 32'd0);
    chk("t5_rst_count", 32'(position_count), 32'd0);
    chk("t5_rst_busy",  32'(position_busy),  32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Test 6a: zero length
    set_params(0, 0, 3, 0);
    for (int b = 0; b < 8; b++) begin
      beat(b == 0, 1'b1);
      chk($sformatf("t6a_valid_b%0d", b), 32'(position_valid), 32'd0);
    end
    chk("t6a_busy", 32'(position_busy), 32'd0);

    // Test 6b: one window of two beats
    set_params(0, 2, 0, 1);
    beat(1'b1, 1'b1);
    chk("t6b_b0_valid", 32'(position_valid), 32'd1);
    chk("t6b_b0_first", 32'(position_first), 32'd1);
    beat(1'b0, 1'b1);
    chk("t6b_b1_valid", 32'(position_valid), 32'd1);
    chk("t6b_b1_last",  32'(position_last),  32'd1);
    chk("t6b_b1_count", 32'(position_count), 32'd1);
    chk("t6b_busy",     32'(position_busy),  32'd0);
    for (int b = 2; b < 5; b++) begin
      beat(1'b0, 1'b1);
      chk($sformatf("t6b_done_valid_b%0d", b), 32'(position_valid), 32'd0);
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
